pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 8'd255, giving the maximum number of memory wait cycles before a timeout error.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- rf_ra0_id / rf_ra1_id  in  5 each  ID source register addresses
- rf_re0_id / rf_re1_id  in  1 each  ID source read enables
- rf_wa_ex  in  5  EX destination register
- rf_we_ex  in  1  EX register write enable
- mem_read_ex  in  1  EX instruction is a load
- br_taken_ex  in  1  EX branch or jump redirect
- dmem_req_mem  in  1  MEM stage data-memory request
- dmem_ready_mem  in  1  data memory completes the request this cycle
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold the PC and each pipeline register
- flush_if_id, flush_id_ex, flush_mem_wb  out  1 each  load a bubble into the register
- err_timeout  out  1  sticky memory-timeout flag

Function
REQ-003 The FSM SHALL have states RUN, MEM_WAIT and ERR, and SHALL hold a wait counter wait_cnt[7:0].
REQ-004 The load-use hazard SHALL be mem_read_ex & rf_we_ex & (rf_wa_ex!=0) & ((rf_re0_id & rf_ra0_id==rf_wa_ex) | (rf_re1_id & rf_ra1_id==rf_wa_ex)).
REQ-005 The memory stall SHALL be dmem_req_mem & ~dmem_ready_mem.
REQ-006 All outputs SHALL be combinational from the state and the current inputs, with no added latency.
REQ-007 In state RUN with a memory stall, the block SHALL assert all four stall outputs and flush_mem_wb, SHALL hold all other flushes low, SHALL go to MEM_WAIT, and SHALL set wait_cnt to 1.
REQ-008 In state MEM_WAIT, the outputs SHALL be the same as in REQ-007 while ~dmem_ready_mem, and wait_cnt SHALL increment each cycle.
REQ-009 In state MEM_WAIT, when dmem_ready_mem is high, the block SHALL assert no stall, SHALL return to RUN the same cycle, and SHALL clear wait_cnt.
REQ-010 In state MEM_WAIT with ~dmem_ready_mem and wait_cnt==MEM_TIMEOUT, the block SHALL go to ERR and set err_timeout.
REQ-011 In state ERR, the block SHALL assert all four stall outputs and flush_mem_wb permanently until reset; ERR SHALL be left only by reset.
REQ-012 In state RUN with no memory stall and br_taken_ex, the block SHALL assert flush_if_id and flush_id_ex; a load-use hazard in the same cycle SHALL be ignored.
REQ-013 In state RUN with a load-use hazard only, the block SHALL assert stall_pc, stall_if_id and flush_id_ex, with stall_id_ex=0 and stall_ex_mem=0; this lasts one cycle per hazard.
REQ-014 Priority SHALL be ERR > memory stall > branch > load-use > none; with none, all outputs are 0.
REQ-015 A branch that is pending in EX during MEM_WAIT SHALL remain held by stall_ex_mem, and SHALL be flushed in the first cycle after the wait ends.
REQ-016 wait_cnt SHALL saturate and never wrap.

Reset
REQ-017 While rst is high, the block SHALL be in state RUN with wait_cnt=0 and err_timeout=0, and all stall and flush outputs SHALL be 0, regardless of clk.
REQ-018 A reset asserted during MEM_WAIT or ERR SHALL abort the state immediately, with no residual stall after rst falls.

Configuration
REQ-019 With PIPE_CTRL_PERF_EN defined, the block SHALL add output ports stall_cycles[31:0] and flush_count[31:0].
REQ-020 stall_cycles SHALL increment in every cycle with stall_pc=1.
REQ-021 flush_count SHALL increment in every cycle with flush_id_ex=1.
REQ-022 Both counters SHALL clear on rst and wrap modulo 2^32.
REQ-023 Without PIPE_CTRL_PERF_EN, the ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 Load-use: mem_read_ex=1, rf_we_ex=1, rf_wa_ex=5, rf_ra1_id=5, rf_re1_id=1 -> stall_pc=stall_if_id=flush_id_ex=1 for 1 cycle; rf_wa_ex=0 gives no stall.
REQ-025 Branch+load-use at the same time: br_taken_ex=1 with the REQ-024 hazard -> flush_if_id=flush_id_ex=1, stall_pc=0.
REQ-026 Memory wait: dmem_req_mem=1, ready low for 3 cycles -> all stalls plus flush_mem_wb for 3 cycles; ready on the 4th cycle -> outputs 0, state RUN, wait_cnt=0.
REQ-027 Timeout: MEM_TIMEOUT=4, ready held low -> err_timeout=1 after the 5th wait cycle, stalls held for 20 further cycles; rst pulse -> all cleared.
REQ-028 Async reset: rst asserted between clk edges in MEM_WAIT -> outputs 0 before the next edge.
REQ-029 PERF (macro defined): 2 load-use hazards plus 1 branch -> stall_cycles=2, flush_count=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard controller.
// Generates the PC/pipeline-register stall and flush controls for load-use
// hazards, taken branches and data-memory wait states. A memory wait that
// lasts past MEM_TIMEOUT cycles locks the pipeline in an error state until
// reset.
// Optional build macro PIPE_CTRL_PERF_EN adds the stall_cycles and
// flush_count performance counters.
module pipe_hazard_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rf_ra0_id,
    input  logic [4:0] rf_ra1_id,
    input  logic       rf_re0_id,
    input  logic       rf_re1_id,
    input  logic [4:0] rf_wa_ex,
    input  logic       rf_we_ex,
    input  logic       mem_read_ex,
    input  logic       br_taken_ex,
    input  logic       dmem_req_mem,
    input  logic       dmem_ready_mem,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       stall_id_ex,
    output logic       stall_ex_mem,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic       flush_mem_wb,
    output logic       err_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;

    logic        load_use;
    logic        mem_stall;
    logic        stall_pc_c, stall_if_id_c, stall_id_ex_c, stall_ex_mem_c;
    logic        flush_if_id_c, flush_id_ex_c, flush_mem_wb_c;

    // Hazard detection terms
    always_comb begin
        load_use  = mem_read_ex & rf_we_ex & (rf_wa_ex != 5'd0) &
                    ((rf_re0_id & (rf_ra0_id == rf_wa_ex)) |
                     (rf_re1_id & (rf_ra1_id == rf_wa_ex)));
        mem_stall = dmem_req_mem & ~dmem_ready_mem;
    end

    // Next-state and control outputs; priority ERR > memory > branch > load-use
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        err_d          = err_q;
        stall_pc_c     = 1'b0;
        stall_if_id_c  = 1'b0;
        stall_id_ex_c  = 1'b0;
        stall_ex_mem_c = 1'b0;
        flush_if_id_c  = 1'b0;
        flush_id_ex_c  = 1'b0;
        flush_mem_wb_c = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    stall_pc_c     = 1'b1;
                    stall_if_id_c  = 1'b1;
                    stall_id_ex_c  = 1'b1;
                    stall_ex_mem_c = 1'b1;
                    flush_mem_wb_c = 1'b1;
                    state_d        = MEM_WAIT;
                    wait_cnt_d     = 8'd1;
                end else if (br_taken_ex) begin
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                end else if (load_use) begin
                    stall_pc_c    = 1'b1;
                    stall_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready_mem) begin
                    // A branch held in EX throughout the wait leaves EX on this
                    // cycle, so its redirect flush must be issued now.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (br_taken_ex) begin
                        flush_if_id_c = 1'b1;
                        flush_id_ex_c = 1'b1;
                    end
                end else begin
                    stall_pc_c     = 1'b1;
                    stall_if_id_c  = 1'b1;
                    stall_id_ex_c  = 1'b1;
                    stall_ex_mem_c = 1'b1;
                    flush_mem_wb_c = 1'b1;
                    if (wait_cnt_q == MEM_TIMEOUT) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ERR: begin
                stall_pc_c     = 1'b1;
                stall_if_id_c  = 1'b1;
                stall_id_ex_c  = 1'b1;
                stall_ex_mem_c = 1'b1;
                flush_mem_wb_c = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Controls are forced low for the whole time reset is held
    always_comb begin
        stall_pc     = stall_pc_c     & ~rst;
        stall_if_id  = stall_if_id_c  & ~rst;
        stall_id_ex  = stall_id_ex_c  & ~rst;
        stall_ex_mem = stall_ex_mem_c & ~rst;
        flush_if_id  = flush_if_id_c  & ~rst;
        flush_id_ex  = flush_id_ex_c  & ~rst;
        flush_mem_wb = flush_mem_wb_c & ~rst;
        err_timeout  = err_q;
    end

    // State, wait counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Performance counter increments, wrapping modulo 2^32
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, stall_pc};
        flush_count_d  = flush_count_q + {31'd0, flush_id_ex};
        stall_cycles   = stall_cycles_q;
        flush_count    = flush_count_q;
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    // Output vector order: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    //                       flush_if_id, flush_id_ex, flush_mem_wb}
    localparam logic [6:0] NONE     = 7'b0000000;
    localparam logic [6:0] ALLSTALL = 7'b1111001;
    localparam logic [6:0] BRFL     = 7'b0000110;
    localparam logic [6:0] LUSE     = 7'b1100010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rf_ra0_id = '0, rf_ra1_id = '0, rf_wa_ex = '0;
    logic       rf_re0_id = 1'b0, rf_re1_id = 1'b0, rf_we_ex = 1'b0;
    logic       mem_read_ex = 1'b0, br_taken_ex = 1'b0;
    logic       dmem_req_mem = 1'b0, dmem_ready_mem = 1'b0;
    logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic       flush_if_id, flush_id_ex, flush_mem_wb, err_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif
    logic [6:0] obs;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(8'(TO))) dut (
        .clk(clk), .rst(rst),
        .rf_ra0_id(rf_ra0_id), .rf_ra1_id(rf_ra1_id),
        .rf_re0_id(rf_re0_id), .rf_re1_id(rf_re1_id),
        .rf_wa_ex(rf_wa_ex), .rf_we_ex(rf_we_ex),
        .mem_read_ex(mem_read_ex), .br_taken_ex(br_taken_ex),
        .dmem_req_mem(dmem_req_mem), .dmem_ready_mem(dmem_ready_mem),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_mem_wb(flush_mem_wb), .err_timeout(err_timeout)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                  flush_if_id, flush_id_ex, flush_mem_wb};

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_ra0_id = '0; rf_ra1_id = '0; rf_wa_ex = '0;
        rf_re0_id = 0; rf_re1_id = 0; rf_we_ex = 0;
        mem_read_ex = 0; br_taken_ex = 0;
        dmem_req_mem = 0; dmem_ready_mem = 0;
    endtask

    task automatic set_hazard();
        mem_read_ex = 1; rf_we_ex = 1; rf_wa_ex = 5'd5;
        rf_ra1_id = 5'd5; rf_re1_id = 1;
    endtask

    task automatic pulse_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        set_hazard();
        dmem_req_mem = 1;
        #2;
        checks++;
        if (obs !== NONE) begin
            errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, NONE);
        end
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b exp=0", err_timeout);
        end
        idle();
        step();
        rst = 0;
        #2;
        checks++;
        if (obs !== NONE) begin
            errors++; $display("FAIL after_reset_idle got=%b exp=%b", obs, NONE);
        end
        step();
    endtask

    task automatic test_load_use();
        set_hazard();
        #2;
        checks++;
        if (obs !== LUSE) begin
            errors++; $display("FAIL load_use_ra1 got=%b exp=%b", obs, LUSE);
        end
        step();
        idle();
        #2;
        checks++;
        if (obs !== NONE) begin
            errors++; $display("FAIL load_use_one_cycle got=%b exp=%b", obs, NONE);
        end
        step();
        set_hazard();
        rf_wa_ex = 5'd0; rf_ra1_id = 5'd0;
        #2;
        checks++;
        if (obs !== NONE) begin
            errors++; $display("FAIL load_use_r0 got=%b exp=%b", obs, NONE);
        end
        step();
        idle();
        mem_read_ex = 1; rf_we_ex = 1; rf_wa_ex = 5'd9; rf_ra0_id = 5'd9; rf_re0_id = 1;
        #2;
        checks++;
        if (obs !== LUSE) begin
            errors++; $display("FAIL load_use_ra0 got=%b exp=%b", obs, LUSE);
        end
        rf_re0_id = 0;
        #1;
        checks++;
        if (obs !== NONE) begin
            errors++; $display("FAIL load_use_no_re got=%b exp=%b", obs, NONE);
        end
        step();
        idle();
    endtask

    task automatic test_branch_priority();
        set_hazard();
        br_taken_ex = 1;
        #2;
        checks++;
        if (obs !== BRFL) begin
            errors++; $display("FAIL branch_over_load_use got=%b exp=%b", obs, BRFL);
        end
        step();
        idle();
    endtask

    task automatic test_mem_wait();
        dmem_req_mem = 1; dmem_ready_mem = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (obs !== ALLSTALL) begin
                errors++; $display("FAIL mem_wait_cycle%0d got=%b exp=%b", i, obs, ALLSTALL);
            end
            step();
        end
        checks++;
        if (dut.wait_cnt_q !== 8'd3) begin
            errors++; $display("FAIL mem_wait_cnt got=%0d exp=3", dut.wait_cnt_q);
        end
        dmem_ready_mem = 1;
        #2;
        checks++;
        if (obs !== NONE) begin
            errors++; $display("FAIL mem_ready got=%b exp=%b", obs, NONE);
        end
        step();
        idle();
        #2;
        checks++;
        if (dut.wait_cnt_q !== 8'd0 || obs !== NONE) begin
            errors++;
            $display("FAIL mem_done got=%b cnt=%0d exp=%b cnt=0", obs, dut.wait_cnt_q, NONE);
        end
        step();
        // Branch held in EX across a memory wait is flushed when the wait ends
        dmem_req_mem = 1; br_taken_ex = 1;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (obs !== ALLSTALL) begin
                errors++; $display("FAIL br_wait_cycle%0d got=%b exp=%b", i, obs, ALLSTALL);
            end
            step();
        end
        dmem_ready_mem = 1;
        #2;
        checks++;
        if (obs !== BRFL) begin
            errors++; $display("FAIL br_after_wait got=%b exp=%b", obs, BRFL);
        end
        step();
        idle();
        #2;
        checks++;
        if (obs !== NONE) begin
            errors++; $display("FAIL br_after_wait_idle got=%b exp=%b", obs, NONE);
        end
        step();
    endtask

    task automatic test_timeout();
        pulse_reset();
        dmem_req_mem = 1; dmem_ready_mem = 0;
        // edges already taken before cycle i is i-1; flag rises after the 5th
        for (int i = 1; i <= 6; i++) begin
            #2;
            checks++;
            if (obs !== ALLSTALL || err_timeout !== (i > 5)) begin
                errors++;
                $display("FAIL timeout_cycle%0d got=%b err=%b exp=%b err=%b",
                         i, obs, err_timeout, ALLSTALL, (i > 5));
            end
            step();
        end
        dmem_req_mem = 0; dmem_ready_mem = 1; br_taken_ex = 1;
        for (int i = 0; i < 20; i++) begin
            #2;
            checks++;
            if (obs !== ALLSTALL || err_timeout !== 1'b1) begin
                errors++;
                $display("FAIL err_hold%0d got=%b err=%b exp=%b err=1", i, obs, err_timeout, ALLSTALL);
            end
            step();
        end
        rst = 1;
        #1;
        checks++;
        if (obs !== NONE || err_timeout !== 1'b0) begin
            errors++; $display("FAIL err_reset got=%b err=%b exp=%b err=0", obs, err_timeout, NONE);
        end
        step();
        rst = 0;
        idle();
        #2;
        checks++;
        if (obs !== NONE || err_timeout !== 1'b0) begin
            errors++; $display("FAIL err_cleared got=%b err=%b exp=%b err=0", obs, err_timeout, NONE);
        end
        step();
    endtask

    task automatic test_async_reset();
        dmem_req_mem = 1; dmem_ready_mem = 0;
        step();
        step();
        #2;
        rst = 1;
        #1;
        checks++;
        if (obs !== NONE) begin
            errors++; $display("FAIL async_reset got=%b exp=%b", obs, NONE);
        end
        step();
        idle();
        rst = 0;
        #2;
        checks++;
        if (obs !== NONE) begin
            errors++; $display("FAIL no_residual got=%b exp=%b", obs, NONE);
        end
        step();
    endtask

    task automatic test_random();
        int         m_wait;
        bit         m_err, nerr, lu;
        logic [6:0] exp;
        m_wait = 0; m_err = 0;
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_err && ($urandom_range(0, 3) == 0)) begin
                pulse_reset();
                m_wait = 0; m_err = 0;
            end
            rf_ra0_id = 5'($urandom_range(0, 3));
            rf_ra1_id = 5'($urandom_range(0, 3));
            rf_wa_ex  = 5'($urandom_range(0, 3));
            rf_re0_id = 1'($urandom); rf_re1_id = 1'($urandom);
            rf_we_ex = 1'($urandom); mem_read_ex = 1'($urandom);
            br_taken_ex = ($urandom_range(0, 3) == 0);
            dmem_req_mem = ($urandom_range(0, 2) == 0);
            dmem_ready_mem = ($urandom_range(0, 2) != 0);
            lu = mem_read_ex && rf_we_ex && rf_wa_ex != 0 &&
                 ((rf_re0_id && rf_ra0_id == rf_wa_ex) || (rf_re1_id && rf_ra1_id == rf_wa_ex));
            nerr = m_err;
            if (m_err) exp = ALLSTALL;
            else if (m_wait > 0 && dmem_ready_mem) begin
                exp = br_taken_ex ? BRFL : NONE;
                m_wait = 0;
            end else if (m_wait > 0 || (dmem_req_mem && !dmem_ready_mem)) begin
                exp = ALLSTALL;
                if (m_wait == TO) nerr = 1;
                m_wait = (m_wait < 255) ? m_wait + 1 : 255;
            end else if (br_taken_ex) exp = BRFL;
            else if (lu) exp = LUSE;
            else exp = NONE;
            #2;
            checks++;
            if (obs !== exp || err_timeout !== m_err) begin
                errors++;
                $display("FAIL random%0d got=%b err=%b exp=%b err=%b", n, obs, err_timeout, exp, m_err);
            end
            step();
            m_err = nerr;
        end
        idle();
        pulse_reset();
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        pulse_reset();
        #2;
        checks++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            errors++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
        set_hazard(); step(); idle(); step();
        set_hazard(); step(); idle(); step();
        br_taken_ex = 1; step(); idle(); step();
        #2;
        checks++;
        if (stall_cycles !== 32'd2 || flush_count !== 32'd3) begin
            errors++; $display("FAIL perf_counts got=%0d/%0d exp=2/3", stall_cycles, flush_count);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_random();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
